// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Brief    : Shared state encoding, owner codes and size codes for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_if
// Brief    : SRAM-like request/response bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Shares one SRAM-like slave between instruction and data masters,
//            one transaction in flight, owner locked from request to data_ok.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master axi
);

  state_t            r_state;
  logic              r_owner;

  logic              w_sel;
  logic              w_src;
  logic              w_req;
  logic              w_route_ok;
  logic              w_wr;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_sel = (data.req && (DATA_FIRST || !inst.req)) ? OWN_D : OWN_I;
    w_src = (r_state == ST_IDLE) ? w_sel : r_owner;

    case (r_state)
      ST_IDLE: w_req = inst.req | data.req;
      ST_REQ:  w_req = (r_owner == OWN_D) ? data.req : inst.req;
      default: w_req = 1'b0;
    endcase

    // A completion in IDLE with nobody asking belongs to no one.
    w_route_ok = (r_state != ST_IDLE) || w_req;

    w_wr    = (w_src == OWN_D) ? data.wr    : inst.wr;
    w_size  = (w_src == OWN_D) ? data.size  : inst.size;
    w_addr  = (w_src == OWN_D) ? data.addr  : inst.addr;
    w_wdata = (w_src == OWN_D) ? data.wdata : inst.wdata;
  end

  assign axi.req   = w_req;
  assign axi.wr    = w_wr;
  assign axi.size  = w_size;
  assign axi.addr  = w_addr;
  assign axi.wdata = w_wdata;

  assign inst.rdata   = axi.rdata;
  assign data.rdata   = axi.rdata;
  assign inst.addr_ok = axi.addr_ok & w_req & (w_src == OWN_I);
  assign data.addr_ok = axi.addr_ok & w_req & (w_src == OWN_D);
  assign inst.data_ok = axi.data_ok & w_route_ok & (w_src == OWN_I);
  assign data.data_ok = axi.data_ok & w_route_ok & (w_src == OWN_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_I;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Same-cycle addr_ok and data_ok completes without leaving IDLE.
          if (w_req && !axi.addr_ok) begin
            r_owner <= w_sel;
            r_state <= ST_REQ;
          end else if (w_req && !axi.data_ok) begin
            r_owner <= w_sel;
            r_state <= ST_BUSY;
          end
        end
        ST_REQ: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
          end else if (axi.addr_ok) begin
            r_state <= axi.data_ok ? ST_IDLE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (axi.data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
